tag_match_pipe: RTL and testbench

TAG_MATCH_PIPE -- requirements
Module: tag_match_pipe

---
 rtl/tag_match_pipe_pkg.sv | 24 ++
 rtl/identity_comparator.sv | 20 ++
 rtl/tag_match_pipe_way.sv | 51 +++++
 rtl/tag_match_pipe.sv | 146 ++++++++++++++
 tb/tb_tag_match_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tag_match_pipe_pkg.sv
//==============================================================================
// Module  : tag_match_pipe_pkg
// Brief   : Shared cache constants and the way-index width helper.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package tag_match_pipe_pkg;

  localparam int STATS_CNT_W = 32;

  // Smallest width able to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/identity_comparator.sv
//==============================================================================
// Module  : identity_comparator
// Brief   : Combinational equality compare of two BW-bit operands.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module identity_comparator #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  output logic          eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

`default_nettype wire

// File: rtl/tag_match_pipe_way.sv
//==============================================================================
// Module  : tag_match_way
// Brief   : One way: tag/valid storage and a valid-gated tag comparator.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tag_match_way #(
  parameter int BW_TAG = 20
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              fill_i,
  input  logic              inval_i,
  input  logic [BW_TAG-1:0] fill_tag_i,
  input  logic [BW_TAG-1:0] cmp_tag_i,
  output logic              match_o
);

  logic [BW_TAG-1:0] r_tag;
  logic              r_valid;
  logic              w_eq;

  // Tag storage carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge clock_i) begin
    if (fill_i && !inval_i) r_tag <= fill_tag_i;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_valid <= 1'b0;
    end else if (inval_i) begin
      r_valid <= 1'b0;
    end else if (fill_i) begin
      r_valid <= 1'b1;
    end
  end

  identity_comparator #(
    .BW (BW_TAG)
  ) u_cmp (
    .a_i  (cmp_tag_i),
    .b_i  (r_tag),
    .eq_o (w_eq)
  );

  assign match_o = w_eq && r_valid;

endmodule

`default_nettype wire

// File: rtl/tag_match_pipe.sv
//==============================================================================
// Module  : tag_match_pipe
// Brief   : Two-stage tag lookup pipeline over N_WAYS tag/valid entries.
//           Optional hit/miss counters enabled by TAG_MATCH_PIPE_STATS_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tag_match_pipe
  import tag_match_pipe_pkg::*;
#(
  parameter  int BW_TAG = 20,
  parameter  int N_WAYS = 4,
  localparam int BW_WAY = clog2(N_WAYS)
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [BW_TAG-1:0]      req_tag_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [BW_WAY-1:0]      rsp_way_o,
  output logic                   rsp_multi_o,
  input  logic                   fill_valid_i,
  input  logic [BW_WAY-1:0]      fill_way_i,
  input  logic [BW_TAG-1:0]      fill_tag_i,
  input  logic                   inval_all_i,
  output logic [STATS_CNT_W-1:0] hit_count_o,
  output logic [STATS_CNT_W-1:0] miss_count_o
);

  logic              r_s1_valid;
  logic [BW_TAG-1:0] r_s1_tag;
  logic              r_s2_valid;
  logic              r_s2_hit;
  logic [BW_WAY-1:0] r_s2_way;
  logic              r_s2_multi;

  logic [N_WAYS-1:0] w_match;
  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_req_fire;
  logic              w_hit;
  logic              w_multi;
  logic [BW_WAY-1:0] w_way;

  assign w_s2_free   = !r_s2_valid || rsp_ready_i;
  assign w_s1_adv    = r_s1_valid && w_s2_free;
  assign req_ready_o = !r_s1_valid || w_s1_adv;
  assign w_req_fire  = req_valid_i && req_ready_o;

  // Out-of-range fill indices select no way and are thereby ignored.
  for (genvar g = 0; g < N_WAYS; g++) begin : g_way
    logic w_fill_sel;
    assign w_fill_sel = fill_valid_i && (fill_way_i == BW_WAY'(g));

    tag_match_way #(
      .BW_TAG (BW_TAG)
    ) u_way (
      .clock_i    (clock_i),
      .resetn_i   (resetn_i),
      .fill_i     (w_fill_sel),
      .inval_i    (inval_all_i),
      .fill_tag_i (fill_tag_i),
      .cmp_tag_i  (r_s1_tag),
      .match_o    (w_match[g])
    );
  end

  always_comb begin
    w_hit   = |w_match;
    w_multi = (w_match & (w_match - 1'b1)) != '0;
    w_way   = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_way = BW_WAY'(i);
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_req_fire) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_req_fire) r_s1_tag <= req_tag_i;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_way   <= '0;
      r_s2_multi <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_hit   <= w_hit;
      r_s2_way   <= w_way;
      r_s2_multi <= w_multi;
    end else if (rsp_ready_i) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_s2_valid;
  assign rsp_hit_o   = r_s2_hit;
  assign rsp_way_o   = r_s2_way;
  assign rsp_multi_o = r_s2_multi;

`ifdef TAG_MATCH_PIPE_STATS_EN
  logic                   w_rsp_fire;
  logic [STATS_CNT_W-1:0] r_hit_cnt;
  logic [STATS_CNT_W-1:0] r_miss_cnt;

  assign w_rsp_fire = r_s2_valid && rsp_ready_i;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_rsp_fire) begin
      if (r_s2_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + STATS_CNT_W'(1);
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + STATS_CNT_W'(1);
      end
    end
  end

  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tag_match_pipe.sv
//==============================================================================
// Module  : tb_tag_match_pipe
// Brief   : Self-checking bench for tag_match_pipe with a behavioural model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tag_match_pipe;

  localparam int BW_TAG = 20;
  localparam int N_WAYS = 4;
  localparam int BW_WAY = 2;

  logic              clock_i = 1'b0;
  logic              resetn_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [BW_TAG-1:0] req_tag_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic              rsp_hit_o;
  logic [BW_WAY-1:0] rsp_way_o;
  logic              rsp_multi_o;
  logic              fill_valid_i = 1'b0;
  logic [BW_WAY-1:0] fill_way_i = '0;
  logic [BW_TAG-1:0] fill_tag_i = '0;
  logic              inval_all_i = 1'b0;
  logic [31:0]       hit_count_o;
  logic [31:0]       miss_count_o;

  int checks = 0;
  int failures = 0;

  tag_match_pipe #(
    .BW_TAG (BW_TAG),
    .N_WAYS (N_WAYS)
  ) dut (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_tag_i    (req_tag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_hit_o    (rsp_hit_o),
    .rsp_way_o    (rsp_way_o),
    .rsp_multi_o  (rsp_multi_o),
    .fill_valid_i (fill_valid_i),
    .fill_way_i   (fill_way_i),
    .fill_tag_i   (fill_tag_i),
    .inval_all_i  (inval_all_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: way table plus the at-most-two lookups in flight.
  logic [BW_TAG-1:0] m_tag [N_WAYS];
  logic              m_vld [N_WAYS] = '{default: 1'b0};
  logic              m_s1_v = 1'b0;
  logic [BW_TAG-1:0] m_s1_tag = '0;
  logic              m_s2_v = 1'b0;
  logic              m_s2_hit = 1'b0;
  logic [BW_WAY-1:0] m_s2_way = '0;
  logic              m_s2_multi = 1'b0;
  logic [31:0]       m_hits = '0;
  logic [31:0]       m_misses = '0;

  function automatic void lookup(input logic [BW_TAG-1:0] t, output logic h,
                                 output logic [BW_WAY-1:0] w, output logic mu);
    int n;
    n = 0;
    w = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (m_vld[i] && m_tag[i] == t) begin
        if (n == 0) w = BW_WAY'(i);
        n++;
      end
    end
    h  = (n > 0);
    mu = (n > 1);
  endfunction

  always @(posedge clock_i or negedge resetn_i) begin
    logic fire, adv, acc, h, mu;
    logic [BW_WAY-1:0] w;
    if (!resetn_i) begin
      for (int i = 0; i < N_WAYS; i++) m_vld[i] = 1'b0;
      m_s1_v = 1'b0; m_s2_v = 1'b0; m_s2_hit = 1'b0; m_s2_way = '0; m_s2_multi = 1'b0;
      m_hits = '0; m_misses = '0;
    end else begin
      fire = m_s2_v && rsp_ready_i;
      adv  = m_s1_v && (!m_s2_v || rsp_ready_i);
      acc  = req_valid_i && (!m_s1_v || adv);
`ifdef TAG_MATCH_PIPE_STATS_EN
      if (fire) begin
        if (m_s2_hit) m_hits = (m_hits == 32'hFFFF_FFFF) ? m_hits : m_hits + 1;
        else m_misses = (m_misses == 32'hFFFF_FFFF) ? m_misses : m_misses + 1;
      end
`endif
      if (adv) begin
        lookup(m_s1_tag, h, w, mu);
        m_s2_v = 1'b1; m_s2_hit = h; m_s2_way = w; m_s2_multi = mu;
      end else if (fire) begin
        m_s2_v = 1'b0;
      end
      if (acc) begin
        m_s1_v = 1'b1; m_s1_tag = req_tag_i;
      end else if (adv) begin
        m_s1_v = 1'b0;
      end
      if (inval_all_i) begin
        for (int i = 0; i < N_WAYS; i++) m_vld[i] = 1'b0;
      end else if (fill_valid_i && int'(fill_way_i) < N_WAYS) begin
        m_tag[fill_way_i] = fill_tag_i;
        m_vld[fill_way_i] = 1'b1;
      end
    end
  end

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clock_i) begin
    chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_s2_v});
    chk("req_ready", {31'b0, req_ready_o}, {31'b0, !m_s1_v || (!m_s2_v || rsp_ready_i)});
    if (m_s2_v) begin
      chk("rsp_hit", {31'b0, rsp_hit_o}, {31'b0, m_s2_hit});
      chk("rsp_way", {30'b0, rsp_way_o}, {30'b0, m_s2_way});
      chk("rsp_multi", {31'b0, rsp_multi_o}, {31'b0, m_s2_multi});
    end
    chk("hit_count", hit_count_o, m_hits);
    chk("miss_count", miss_count_o, m_misses);
  end

  task automatic cyc();
    @(posedge clock_i);
    #3;
  endtask

  task automatic rsp_lit(input string name, input logic v, input logic h,
                         input logic [BW_WAY-1:0] w, input logic mu);
    chk({name, "_valid"}, {31'b0, rsp_valid_o}, {31'b0, v});
    chk({name, "_hit"},   {31'b0, rsp_hit_o},   {31'b0, h});
    chk({name, "_way"},   {30'b0, rsp_way_o},   {30'b0, w});
    chk({name, "_multi"}, {31'b0, rsp_multi_o}, {31'b0, mu});
  endtask

  task automatic request_one(input logic [BW_TAG-1:0] t);
    cyc(); req_valid_i = 1'b1; req_tag_i = t;
    cyc(); req_valid_i = 1'b0;
    cyc();
  endtask

  task automatic fill(input logic [BW_WAY-1:0] w, input logic [BW_TAG-1:0] t);
    cyc(); fill_valid_i = 1'b1; fill_way_i = w; fill_tag_i = t;
    cyc(); fill_valid_i = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    rsp_lit("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    chk("reset_hit_count", hit_count_o, 32'd0);
    repeat (2) cyc();
    resetn_i = 1'b1;
    rsp_ready_i = 1'b1;
    cyc();
    chk("post_reset_ready", {31'b0, req_ready_o}, 32'd1);

    // Miss on an empty table.
    request_one(20'h12345);
    rsp_lit("miss_empty", 1'b1, 1'b0, 2'd0, 1'b0);
    cyc();
`ifdef TAG_MATCH_PIPE_STATS_EN
    chk("miss_count_one", miss_count_o, 32'd1);
`else
    chk("miss_count_tied", miss_count_o, 32'd0);
`endif

    // Single hit in way 2.
    fill(2'd2, 20'h0ABCD);
    request_one(20'h0ABCD);
    rsp_lit("hit_way2", 1'b1, 1'b1, 2'd2, 1'b0);
    cyc();

    // Duplicate tag in ways 1 and 3: lowest index wins, multi flagged.
    fill(2'd1, 20'h00055);
    fill(2'd3, 20'h00055);
    request_one(20'h00055);
    rsp_lit("multi", 1'b1, 1'b1, 2'd1, 1'b1);
    cyc();

    // Back-to-back under a 3-cycle downstream stall.
    cyc(); rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_tag_i = 20'h0ABCD;
    cyc(); req_tag_i = 20'h00055;
    chk("b2b_ready_s1", {31'b0, req_ready_o}, 32'd1);
    cyc(); req_tag_i = 20'h12345;
    chk("b2b_ready_full", {31'b0, req_ready_o}, 32'd0);
    rsp_lit("stall0", 1'b1, 1'b1, 2'd2, 1'b0);
    cyc();
    rsp_lit("stall1", 1'b1, 1'b1, 2'd2, 1'b0);
    cyc();
    rsp_lit("stall2", 1'b1, 1'b1, 2'd2, 1'b0);
    rsp_ready_i = 1'b1;
    #1;
    chk("b2b_ready_release", {31'b0, req_ready_o}, 32'd1);
    cyc(); req_valid_i = 1'b0;
    rsp_lit("order_b", 1'b1, 1'b1, 2'd1, 1'b1);
    cyc();
    rsp_lit("order_c", 1'b1, 1'b0, 2'd0, 1'b0);
    cyc();
    chk("drained", {31'b0, rsp_valid_o}, 32'd0);

    // Invalidate wins over a same-cycle fill.
    cyc(); fill_valid_i = 1'b1; fill_way_i = 2'd0; fill_tag_i = 20'h0F00F; inval_all_i = 1'b1;
    cyc(); fill_valid_i = 1'b0; inval_all_i = 1'b0;
    request_one(20'h0F00F);
    rsp_lit("inval_fill", 1'b1, 1'b0, 2'd0, 1'b0);
    cyc();

    // Reset with both stages occupied.
    fill(2'd2, 20'h0ABCD);
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_tag_i = 20'h0ABCD;
    cyc(); cyc();
    req_valid_i = 1'b0;
    chk("pre_reset_valid", {31'b0, rsp_valid_o}, 32'd1);
    #1 resetn_i = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("async_reset_ready", {31'b0, req_ready_o}, 32'd1);
    chk("async_reset_hits", hit_count_o, 32'd0);
    cyc(); cyc();
    resetn_i = 1'b1; rsp_ready_i = 1'b1;
    cyc(); cyc();
    chk("no_ghost_rsp", {31'b0, rsp_valid_o}, 32'd0);
    request_one(20'h0ABCD);
    rsp_lit("ways_cleared", 1'b1, 1'b0, 2'd0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      req_valid_i  = ($urandom_range(0, 9) < 7);
      req_tag_i    = BW_TAG'($urandom_range(0, 7));
      rsp_ready_i  = ($urandom_range(0, 9) < 7);
      fill_valid_i = ($urandom_range(0, 9) < 2);
      fill_way_i   = BW_WAY'($urandom_range(0, N_WAYS - 1));
      fill_tag_i   = BW_TAG'($urandom_range(0, 7));
      inval_all_i  = ($urandom_range(0, 99) < 2);
    end
    cyc();
    req_valid_i = 1'b0; fill_valid_i = 1'b0; inval_all_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
